if_fetch_buffer: RTL

Fetch-side consumer of the PC register's address stream.
- Accepts each pc_i value, issues an instruction-memory read, and buffers the returned instructions with their PCs in order.
- Presents them to decode over a valid/ready handshake.
- Back-pressures the PC register through fetch_stall_o, which drives the PC register's hazard/hold input.
- Sits between the PC register, instruction memory and the IF/ID stage.

---
 rtl/if_fetch_buffer_pkg.sv | 21 ++
 rtl/if_fetch_buffer_if.sv | 31 +++
 rtl/if_fetch_buffer_fifo.sv | 58 +++++
 rtl/if_fetch_buffer.sv | 118 +++++++++++
 4 files changed

// File: rtl/if_fetch_buffer_pkg.sv
// Shared types and helpers for the instruction fetch buffer.
// Optional halt feature is selected with the FETCH_HALT_EN macro (see if_fetch_buffer.sv).
package fetch_pkg;

    localparam int DEFAULT_XLEN = 32;

    // Canonical RISC-V NOP (addi x0, x0, 0).
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // One buffered instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [DEFAULT_XLEN-1:0] pc;
        logic [DEFAULT_XLEN-1:0] inst;
    } fetch_entry_t;

    // Occupancy counters need one extra bit so that "full" (== depth) is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/if_fetch_buffer_if.sv
// Bus bundle of the fetch buffer: memory request/response plus decode handshake.
//
// Handshake rule for every valid/ready pair here: a transfer happens on a rising
// clock edge where valid and ready are both 1. Once raised, valid does not depend
// on ready in the same cycle. The memory response channel has no ready: the fetch
// buffer always accepts rsp_valid_i, and responses return in request order.
interface if_fetch_buffer_if #(
    parameter int XLEN = fetch_pkg::DEFAULT_XLEN
);
    logic            req_valid_o;
    logic [XLEN-1:0] req_addr_o;
    logic            req_ready_i;
    logic            rsp_valid_i;
    logic [XLEN-1:0] rsp_data_i;
    logic            inst_valid_o;
    logic [XLEN-1:0] inst_o;
    logic [XLEN-1:0] inst_pc_o;
    logic            inst_ready_i;

    // Fetch buffer side.
    modport master (
        output req_valid_o, req_addr_o, inst_valid_o, inst_o, inst_pc_o,
        input  req_ready_i, rsp_valid_i, rsp_data_i, inst_ready_i
    );

    // Memory and decode side.
    modport slave (
        input  req_valid_o, req_addr_o, inst_valid_o, inst_o, inst_pc_o,
        output req_ready_i, rsp_valid_i, rsp_data_i, inst_ready_i
    );
endinterface

// File: rtl/if_fetch_buffer_fifo.sv
// Generic synchronous FIFO with registered storage and zero-latency head read.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module fetch_fifo import fetch_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        start_i,
    input  logic                        push,
    input  logic                        pop,
    input  logic                        clear,
    input  logic [WIDTH-1:0]            wdata,
    output logic [WIDTH-1:0]            rdata,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                        full,
    output logic                        empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];
    assign count   = cnt;

    // Pointer, count and storage update; clear drops contents but keeps storage bits.
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/if_fetch_buffer.sv
// Fetch buffer between the PC register, instruction memory and the IF/ID stage.
// Issues one memory read per PC, pairs in-order responses with their PCs and
// hands them to decode. Define FETCH_HALT_EN to stop fetching after HALT_PC.
module if_fetch_buffer import fetch_pkg::*; #(
    parameter int              DEPTH   = 4,
    parameter int              XLEN    = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] HALT_PC = XLEN'(248)
) (
    input  logic            clk_i,
    input  logic            start_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            flush_i,
    output logic            fetch_stall_o,
    output logic            halted_o,
    if_fetch_buffer_if.master bus
);
    localparam int CW = cnt_width(DEPTH);

    logic [CW-1:0]     pend_cnt;
    logic [CW-1:0]     inst_cnt;
    logic [CW-1:0]     discard_q;
    logic [CW-1:0]     flush_drop;
    logic [XLEN-1:0]   pend_head;
    logic [2*XLEN-1:0] inst_head;
    logic              credit_ok;
    logic              req_valid;
    logic              issue_fire;
    logic              rsp_take;
    logic              inst_pop;
    logic              halted;
    logic              unused_pend_full;
    logic              unused_pend_empty;
    logic              unused_inst_full;
    logic              unused_inst_empty;

    // Every slot is either waiting on memory or holding an instruction.
    assign credit_ok  = ({1'b0, pend_cnt} + {1'b0, inst_cnt}) < (CW+1)'(DEPTH);
    assign req_valid  = start_i & credit_ok & ~flush_i & ~halted;
    assign issue_fire = req_valid & bus.req_ready_i;

    // A response is kept only when no older, flushed request is still owed to us.
    assign rsp_take = bus.rsp_valid_i & ~flush_i & (discard_q == '0) & (pend_cnt != '0);
    assign inst_pop = (inst_cnt != '0) & bus.inst_ready_i;

    // In a flush cycle the arriving response is dropped whichever list it belongs to.
    assign flush_drop = CW'(bus.rsp_valid_i & ((discard_q != '0) | (pend_cnt != '0)));

    assign bus.req_valid_o  = req_valid;
    assign bus.req_addr_o   = pc_i;
    assign fetch_stall_o    = ~issue_fire;
    assign bus.inst_valid_o = (inst_cnt != '0);
    assign bus.inst_pc_o    = inst_head[2*XLEN-1:XLEN];
    assign bus.inst_o       = inst_head[XLEN-1:0];
    assign halted_o         = halted;

    fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pend_fifo (
        .clk_i   (clk_i),
        .start_i (start_i),
        .push    (issue_fire),
        .pop     (rsp_take),
        .clear   (flush_i),
        .wdata   (pc_i),
        .rdata   (pend_head),
        .count   (pend_cnt),
        .full    (unused_pend_full),
        .empty   (unused_pend_empty)
    );

    fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_inst_fifo (
        .clk_i   (clk_i),
        .start_i (start_i),
        .push    (rsp_take),
        .pop     (inst_pop),
        .clear   (flush_i),
        .wdata   ({pend_head, bus.rsp_data_i}),
        .rdata   (inst_head),
        .count   (inst_cnt),
        .full    (unused_inst_full),
        .empty   (unused_inst_empty)
    );

    // Count of responses still owed for requests that a flush threw away.
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            discard_q <= '0;
        end else if (flush_i) begin
            discard_q <= discard_q + pend_cnt - flush_drop;
        end else if (bus.rsp_valid_i && (discard_q != '0)) begin
            discard_q <= discard_q - CW'(1);
        end
    end

`ifdef FETCH_HALT_EN
    logic halted_q;

    // Sticky halt once the halt address has been issued; only reset clears it.
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            halted_q <= 1'b0;
        end else if (issue_fire && (pc_i == HALT_PC)) begin
            halted_q <= 1'b1;
        end
    end

    assign halted = halted_q;
`else
    logic unused_halt_pc;

    assign halted         = 1'b0;
    assign unused_halt_pc = ^HALT_PC;
`endif

`ifndef SYNTHESIS
    // Every response must belong to an accepted request, kept or discarded.
    rsp_has_owner: assert property (@(posedge clk_i) disable iff (!start_i)
        bus.rsp_valid_i |-> ((discard_q != '0) || (pend_cnt != '0)));
`endif
endmodule
